// File: rtl/alu_control_unit_pkg.sv
// rtl/alu_control_unit_pkg.sv - opcode constants and sequencer state encoding
package alu_control_unit_pkg;

    typedef enum logic [1:0] {
        T0 = 2'd0,
        T1 = 2'd1,
        T2 = 2'd2,
        T3 = 2'd3
    } state_t;

    // Opcodes 0000-0101 match the ALU's own operation encoding.
    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_SLT = 4'b0010;
    localparam logic [3:0] OP_SLL = 4'b0011;
    localparam logic [3:0] OP_SLR = 4'b0100;
    localparam logic [3:0] OP_AND = 4'b0101;
    localparam logic [3:0] OP_MV  = 4'b0110;
    localparam logic [3:0] OP_MVI = 4'b0111;

    function automatic logic is_alu_op(input logic [3:0] op);
        return op <= OP_AND;
    endfunction

endpackage

// File: rtl/alu_control_unit_dec3to8.sv
// rtl/alu_control_unit_dec3to8.sv - register select to one-hot decoder with enable
module dec3to8 #(
    parameter int SEL_W = 3
) (
    input  logic                 en,
    input  logic [SEL_W-1:0]     sel,
    output logic [2**SEL_W-1:0]  onehot
);

    always_comb begin
        onehot = '0;
        if (en) begin
            onehot[sel] = 1'b1;
        end
    end

endmodule

// File: rtl/alu_control_unit.sv
// rtl/alu_control_unit.sv - multicycle instruction sequencer driving the ALU datapath
module alu_control_unit
    import alu_control_unit_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int OP_W   = 4,
    parameter int REG_W  = 3
) (
    input  logic                  Clock,
    input  logic                  Resetn,
    input  logic                  Run,
    input  logic [DATA_W-1:0]     DIN,
    output logic                  IRin,
    output logic [2**REG_W-1:0]   Rin,
    output logic [2**REG_W-1:0]   Rout,
    output logic                  Ain,
    output logic                  Gin,
    output logic                  Gout,
    output logic                  DINout,
    output logic [OP_W-1:0]       alu_op,
    output logic                  Done
);

    localparam int NREG = 2**REG_W;
    localparam int RX_HI = DATA_W - OP_W - 1;
    localparam int RY_HI = RX_HI - REG_W;
    localparam int LOW_W = DATA_W - OP_W - 2*REG_W;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] ir_q, ir_d;

    logic [OP_W-1:0]   opcode;
    logic [REG_W-1:0]  rx_sel, ry_sel;
    logic [NREG-1:0]   rx_onehot, ry_onehot;
    logic [LOW_W-1:0]  unused_ir_low;

    assign opcode        = ir_q[DATA_W-1 -: OP_W];
    assign rx_sel        = ir_q[RX_HI -: REG_W];
    assign ry_sel        = ir_q[RY_HI -: REG_W];
    assign unused_ir_low = ir_q[LOW_W-1:0];

    // Decoders are disabled under reset so no register select can leak out.
    dec3to8 #(.SEL_W(REG_W)) u_dec_rx (
        .en     (Resetn),
        .sel    (rx_sel),
        .onehot (rx_onehot)
    );

    dec3to8 #(.SEL_W(REG_W)) u_dec_ry (
        .en     (Resetn),
        .sel    (ry_sel),
        .onehot (ry_onehot)
    );

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q <= T0;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        case (state_q)
            T0: begin
                if (Run) begin
                    ir_d    = DIN;
                    state_d = T1;
                end
            end
            T1:      state_d = is_alu_op(opcode) ? T2 : T0;
            T2:      state_d = T3;
            T3:      state_d = T0;
            default: state_d = T0;
        endcase
    end

    // Every output is forced low while Resetn is asserted, including IRin in T0.
    always_comb begin
        IRin   = 1'b0;
        Rin    = '0;
        Rout   = '0;
        Ain    = 1'b0;
        Gin    = 1'b0;
        Gout   = 1'b0;
        DINout = 1'b0;
        alu_op = '0;
        Done   = 1'b0;
        if (Resetn) begin
            case (state_q)
                T0: IRin = Run;
                T1: begin
                    if (is_alu_op(opcode)) begin
                        Rout   = rx_onehot;
                        Ain    = 1'b1;
                        alu_op = opcode;
                    end else if (opcode == OP_MV) begin
                        Rout = ry_onehot;
                        Rin  = rx_onehot;
                        Done = 1'b1;
                    end else if (opcode == OP_MVI) begin
                        DINout = 1'b1;
                        Rin    = rx_onehot;
                        Done   = 1'b1;
                    end else begin
                        Done = 1'b1;
                    end
                end
                T2: begin
                    Rout   = ry_onehot;
                    Gin    = 1'b1;
                    alu_op = opcode;
                end
                T3: begin
                    Gout   = 1'b1;
                    Rin    = rx_onehot;
                    Done   = 1'b1;
                    alu_op = opcode;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_control_unit.sv
// tb/tb_alu_control_unit.sv - randomized model-checked bench for alu_control_unit
module tb_alu_control_unit;

    typedef struct packed {
        logic       irin;
        logic [7:0] rin;
        logic [7:0] rout;
        logic       ain;
        logic       gin;
        logic       gout;
        logic       dinout;
        logic [3:0] aluop;
        logic       done;
    } ov_t;

    logic        Clock;
    logic        Resetn;
    logic        Run;
    logic [15:0] DIN;
    logic        IRin;
    logic [7:0]  Rin;
    logic [7:0]  Rout;
    logic        Ain;
    logic        Gin;
    logic        Gout;
    logic        DINout;
    logic [3:0]  alu_op;
    logic        Done;

    int checks = 0;
    int errors = 0;

    ov_t act;
    assign act = {IRin, Rin, Rout, Ain, Gin, Gout, DINout, alu_op, Done};

    alu_control_unit dut (
        .Clock  (Clock),
        .Resetn (Resetn),
        .Run    (Run),
        .DIN    (DIN),
        .IRin   (IRin),
        .Rin    (Rin),
        .Rout   (Rout),
        .Ain    (Ain),
        .Gin    (Gin),
        .Gout   (Gout),
        .DINout (DINout),
        .alu_op (alu_op),
        .Done   (Done)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    function automatic ov_t mk(int irin, int rin, int rout, int ain, int gin,
                               int gout, int dinout, int aluop, int done);
        ov_t v;
        v.irin   = irin[0];
        v.rin    = rin[7:0];
        v.rout   = rout[7:0];
        v.ain    = ain[0];
        v.gin    = gin[0];
        v.gout   = gout[0];
        v.dinout = dinout[0];
        v.aluop  = aluop[3:0];
        v.done   = done[0];
        return v;
    endfunction

    // Reference model: a fetched word expands into the list of output vectors
    // for the cycles after T0; an empty list means the sequencer is idle in T0.
    ov_t q[$];
    int  done_cnt = 0;
    bit  seen_fetch = 0;
    bit  rst_since = 1;

    function automatic void push_seq(logic [15:0] w);
        int op, rxo, ryo;
        op  = int'(w >> 12);
        rxo = 1 << ((w >> 9) & 16'd7);
        ryo = 1 << ((w >> 6) & 16'd7);
        if (op <= 5) begin
            q.push_back(mk(0, 0, rxo, 1, 0, 0, 0, op, 0));
            q.push_back(mk(0, 0, ryo, 0, 1, 0, 0, op, 0));
            q.push_back(mk(0, rxo, 0, 0, 0, 1, 0, op, 1));
        end else if (op == 6) begin
            q.push_back(mk(0, rxo, ryo, 0, 0, 0, 0, 0, 1));
        end else if (op == 7) begin
            q.push_back(mk(0, rxo, 0, 0, 0, 0, 1, 0, 1));
        end else begin
            q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1));
        end
    endfunction

    always @(negedge Resetn) begin
        q.delete();
        rst_since = 1;
    end

    always @(negedge Clock) begin
        ov_t exp;
        bit  fetch;
        fetch = 0;
        if (!Resetn) begin
            exp = '0;
            q.delete();
            rst_since = 1;
        end else if (q.size() == 0) begin
            exp = '0;
            exp.irin = Run;
            fetch = Run;
        end else begin
            exp = q.pop_front();
        end

        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL model_cmp t=%0t got=%h exp=%h", $time, act, exp);
        end

        checks++;
        if ($countones({Rout, Gout, DINout}) > 1) begin
            errors++;
            $display("FAIL bus_excl t=%0t got=%b exp=at_most_one", $time, {Rout, Gout, DINout});
        end

        if (Done === 1'b1) done_cnt++;
        if (fetch) begin
            if (seen_fetch && !rst_since) begin
                checks++;
                if (done_cnt != 1) begin
                    errors++;
                    $display("FAIL done_per_instr t=%0t got=%0d exp=1", $time, done_cnt);
                end
            end
            push_seq(DIN);
            seen_fetch = 1;
            rst_since  = 0;
            done_cnt   = 0;
        end
    end

    task automatic lit_now(input string name, input ov_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, act, exp);
        end
    endtask

    task automatic step(input logic run, input logic [15:0] din,
                        input string name, input ov_t exp);
        @(posedge Clock);
        #1;
        Run = run;
        DIN = din;
        @(negedge Clock);
        lit_now(name, exp);
    endtask

    localparam ov_t ZERO = '0;

    initial begin
        Resetn = 1'b0;
        Run    = 1'b1;
        DIN    = 16'h0280;
        repeat (2) begin
            @(negedge Clock);
            lit_now("reset_hold", ZERO);
        end
        @(posedge Clock);
        #1 Resetn = 1'b1;
        @(negedge Clock);
        lit_now("release_irin", mk(1, 0, 0, 0, 0, 0, 0, 0, 0));

        step(0, 16'h0000, "add_t1", mk(0, 0, 8'h02, 1, 0, 0, 0, 0, 0));
        step(0, 16'h0000, "add_t2", mk(0, 0, 8'h04, 0, 1, 0, 0, 0, 0));
        step(0, 16'h0000, "add_t3", mk(0, 8'h02, 0, 0, 0, 1, 0, 0, 1));

        step(1, 16'h7A00, "mvi_t0", mk(1, 0, 0, 0, 0, 0, 0, 0, 0));
        step(0, 16'h00FF, "mvi_t1", mk(0, 8'h20, 0, 0, 0, 0, 1, 0, 1));

        step(1, 16'h61C0, "mv_t0",  mk(1, 0, 0, 0, 0, 0, 0, 0, 0));
        step(0, 16'h0000, "mv_t1",  mk(0, 8'h01, 8'h80, 0, 0, 0, 0, 0, 1));

        step(1, 16'h2700, "slt_t0", mk(1, 0, 0, 0, 0, 0, 0, 0, 0));
        step(0, 16'h0000, "slt_t1", mk(0, 0, 8'h08, 1, 0, 0, 0, 2, 0));
        step(0, 16'h0000, "slt_t2", mk(0, 0, 8'h10, 0, 1, 0, 0, 2, 0));
        step(0, 16'h0000, "slt_t3", mk(0, 8'h08, 0, 0, 0, 1, 0, 2, 1));
        step(0, 16'h0000, "idle_a", ZERO);
        step(0, 16'h2700, "idle_b", ZERO);

        step(1, 16'hF000, "nop_t0", mk(1, 0, 0, 0, 0, 0, 0, 0, 0));
        step(0, 16'h0000, "nop_t1", mk(0, 0, 0, 0, 0, 0, 0, 0, 1));

        step(1, 16'h0280, "add2_t0", mk(1, 0, 0, 0, 0, 0, 0, 0, 0));
        step(0, 16'h0000, "add2_t1", mk(0, 0, 8'h02, 1, 0, 0, 0, 0, 0));
        step(0, 16'h0000, "add2_t2", mk(0, 0, 8'h04, 0, 1, 0, 0, 0, 0));
        #2 Resetn = 1'b0;
        #1 lit_now("reset_mid_t2", ZERO);
        @(posedge Clock);
        #1;
        Resetn = 1'b1;
        Run    = 1'b0;
        @(negedge Clock);
        lit_now("post_reset_idle", ZERO);
        step(1, 16'h7A00, "post_reset_t0", mk(1, 0, 0, 0, 0, 0, 0, 0, 0));
        step(0, 16'h0000, "post_reset_t1", mk(0, 8'h20, 0, 0, 0, 0, 1, 0, 1));

        for (int i = 0; i < 3000; i++) begin
            @(posedge Clock);
            #1;
            Resetn = ($urandom_range(0, 249) != 0);
            Run    = ($urandom_range(0, 3) != 0);
            DIN    = 16'($urandom);
        end

        @(posedge Clock);
        #1;
        Resetn = 1'b1;
        Run    = 1'b0;
        repeat (6) @(posedge Clock);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
